// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encoding and sizing helpers for the lab arithmetic datapath
//
// Purpose : types and constants shared by the sequential divider and its helpers.
// Contents: div_state_e   - divider FSM states (IDLE, RUN, DONE)
//           DIV_N         - default operand width
//           DIV_CNT_W     - bit-counter width for the default operand width, $clog2(N)
//           cnt_width()   - bit-counter width for any operand width N >= 2

package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_N     = 4;
    localparam int DIV_CNT_W = $clog2(DIV_N);

    // The counter must be able to hold N-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_add_n_bit.sv
// rtl/full_add_n_bit.sv - N-bit ripple-carry adder
//
// Purpose : {c_out, sum} = a + b + c_in.
// Ports   : a, b  [N-1:0] in  - addends
//           c_in          in  - carry in
//           sum   [N-1:0] out - sum bits
//           c_out         out - carry out of the MSB

module full_add_n_bit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N:0] w_carry;

    assign w_carry[0] = c_in;

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_carry[N];

endmodule

// File: rtl/div_n_seq.sv
// rtl/div_n_seq.sv - sequential N-bit unsigned restoring divider, one quotient bit per clock
//
// Purpose : computes quotient and remainder of dividend / divisor using a start/done handshake.
// Ports   : clk                  in  - system clock, rising edge
//           resetn               in  - synchronous active-low reset
//           start                in  - request a division, sampled only in IDLE
//           dividend   [N-1:0]   in  - captured on the accepted start
//           divisor    [N-1:0]   in  - captured on the accepted start
//           busy                 out - high in RUN and DONE
//           done                 out - one-cycle pulse, results valid from this cycle on
//           quotient   [N-1:0]   out - held until the next completed operation
//           remainder  [N-1:0]   out - held until the next completed operation
//           div_by_zero          out - divide-by-zero flag of the last operation

module div_n_seq
    import arith_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    div_state_e    r_state;
    logic [N:0]    r_rem;       // partial remainder, one bit wider than the operands
    logic [N-1:0]  r_qreg;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [N-1:0]  r_divisor;
    logic [CW-1:0] r_cnt;

    logic [N:0]    w_r_shift;
    logic [N:0]    w_trial;
    logic          w_borrow;
    logic [N:0]    w_rem_next;
    logic [N-1:0]  w_q_next;
    logic          w_unused_cout;

    assign w_r_shift = {r_rem[N-1:0], r_qreg[N-1]};

    // Trial subtraction r - {0, divisor} as r + ~{0, divisor} + 1.
    full_add_n_bit #(
        .N(N + 1)
    ) u_trial_sub (
        .a     (w_r_shift),
        .b     (~{1'b0, r_divisor}),
        .c_in  (1'b1),
        .sum   (w_trial),
        .c_out (w_unused_cout)
    );

    // A negative trial result means the divisor did not fit: keep the shifted value.
    assign w_borrow   = w_trial[N];
    assign w_rem_next = w_borrow ? w_r_shift : w_trial;
    assign w_q_next   = {r_qreg[N-2:0], ~w_borrow};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_qreg      <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_divisor   <= divisor;
                        r_rem       <= '0;
                        r_qreg      <= dividend;
                        r_cnt       <= CW'(N - 1);
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            // Nothing to iterate: publish the saturated result now.
                            r_state     <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_rem  <= w_rem_next;
                    r_qreg <= w_q_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state   <= DONE;
                        done      <= 1'b1;
                        quotient  <= w_q_next;
                        remainder <= w_rem_next[N-1:0];
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
